// File: rtl/ir_err_calc.sv
// ir_err_calc
//   Snapshots the eight 12-bit IR readings when a round-complete strobe arrives.
//   Serially accumulates sum((R_i - L_i) << i) for i = 0..3 over four cycles.
//   Publishes the scaled signed error with a one-cycle valid strobe.
//   Tracks consecutive line-absent rounds and flags a lost line.
//
// Build option:
//   IR_ERR_SAT_EN  when defined, clamp the scaled error to [-2048, 2047];
//                  otherwise truncate it to 12 bits.
//
// Parameters:
//   ERR_SHIFT  arithmetic right shift applied to the 17-bit accumulator.
//   LOST_RNDS  consecutive absent rounds before lost_line asserts (1..15).
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   IR_vld        round-complete strobe (ignored while busy)
//   line_present  line detected this round, sampled with IR_vld
//   IR_R0..IR_R3  right readings, unsigned, index 0 innermost
//   IR_L0..IR_L3  left readings, unsigned
//   error         signed error, positive = line to the right
//   err_vld       one-cycle strobe: error/lost_line updated
//   busy          high while accumulating or publishing
//   lost_line     line absent for >= LOST_RNDS consecutive rounds
module ir_err_calc #(
  parameter int unsigned ERR_SHIFT = 5,
  parameter int unsigned LOST_RNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_vld,
  input  logic        line_present,
  input  logic [11:0] IR_R0,
  input  logic [11:0] IR_R1,
  input  logic [11:0] IR_R2,
  input  logic [11:0] IR_R3,
  input  logic [11:0] IR_L0,
  input  logic [11:0] IR_L1,
  input  logic [11:0] IR_L2,
  input  logic [11:0] IR_L3,
  output logic [11:0] error,
  output logic        err_vld,
  output logic        busy,
  output logic        lost_line
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0][11:0]   r_rgt;
  logic [3:0][11:0]   r_lft;
  logic               r_line;
  logic signed [16:0] r_acc;
  logic [1:0]         r_idx;
  logic [3:0]         r_absent;
  logic [11:0]        r_error;
  logic               r_err_vld;
  logic               r_busy;
  logic               r_lost;

  logic signed [12:0] w_diff;
  logic signed [16:0] w_diff_ext;
  logic signed [16:0] w_term;
  logic signed [16:0] w_scaled;
  logic [11:0]        w_err_next;
  logic [3:0]         w_absent_next;
  logic               w_lost_next;

  // Zero-extended operands make the 13-bit difference exact for any readings.
  assign w_diff     = $signed({1'b0, r_rgt[r_idx]}) - $signed({1'b0, r_lft[r_idx]});
  assign w_diff_ext = {{4{w_diff[12]}}, w_diff};
  assign w_term     = w_diff_ext <<< r_idx;
  assign w_scaled   = r_acc >>> ERR_SHIFT;

  always_comb begin
    w_err_next = w_scaled[11:0];
`ifdef IR_ERR_SAT_EN
    if (w_scaled > 17'sd2047) begin
      w_err_next = 12'h7FF;
    end else if (w_scaled < -17'sd2048) begin
      w_err_next = 12'h800;
    end
`endif
  end

  always_comb begin
    w_absent_next = r_absent;
    if (r_line) begin
      w_absent_next = '0;
    end else if (r_absent != 4'd15) begin
      w_absent_next = r_absent + 4'd1;
    end
    w_lost_next = (32'(w_absent_next) >= LOST_RNDS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rgt     <= '0;
      r_lft     <= '0;
      r_line    <= 1'b0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_absent  <= '0;
      r_error   <= '0;
      r_err_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_err_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (IR_vld) begin
            r_rgt   <= {IR_R3, IR_R2, IR_R1, IR_R0};
            r_lft   <= {IR_L3, IR_L2, IR_L1, IR_L0};
            r_line  <= line_present;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= OUT;
          end
        end
        OUT: begin
          if (r_line) begin
            r_error <= w_err_next;
          end
          r_absent  <= w_absent_next;
          r_lost    <= w_lost_next;
          r_err_vld <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign error     = r_error;
  assign err_vld   = r_err_vld;
  assign busy      = r_busy;
  assign lost_line = r_lost;

endmodule

// File: tb/tb_ir_err_calc.sv
module tb_ir_err_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IR_vld = 1'b0;
  logic        line_present = 1'b0;
  logic [11:0] IR_R0 = '0, IR_R1 = '0, IR_R2 = '0, IR_R3 = '0;
  logic [11:0] IR_L0 = '0, IR_L1 = '0, IR_L2 = '0, IR_L3 = '0;
  logic [11:0] error, error3;
  logic        err_vld, err_vld3;
  logic        busy, busy3;
  logic        lost_line, lost_line3;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  ir_err_calc #(.ERR_SHIFT(5), .LOST_RNDS(8)) dut (
    .clk(clk), .rst(rst), .IR_vld(IR_vld), .line_present(line_present),
    .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
    .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3),
    .error(error), .err_vld(err_vld), .busy(busy), .lost_line(lost_line)
  );

  // Same stimulus, smaller shift: exercises wrap vs. clamp of the scaled value.
  ir_err_calc #(.ERR_SHIFT(3), .LOST_RNDS(8)) dut3 (
    .clk(clk), .rst(rst), .IR_vld(IR_vld), .line_present(line_present),
    .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
    .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3),
    .error(error3), .err_vld(err_vld3), .busy(busy3), .lost_line(lost_line3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic [11:0] r0, r1, r2, r3, l0, l1, l2, l3, input logic lp);
    IR_R0 = r0; IR_R1 = r1; IR_R2 = r2; IR_R3 = r3;
    IR_L0 = l0; IR_L1 = l1; IR_L2 = l2; IR_L3 = l3;
    line_present = lp;
  endtask

  // One round: IR_vld high in cycle N, then observe cycles N+1..N+12.
  // vld2_at / rst_at: cycle offset for an extra IR_vld pulse / reset (0 = none).
  task automatic do_round(input string tag, input logic [11:0] exp_err, input logic exp_lost,
                          input bit chk3, input logic [11:0] exp_err3,
                          input int vld2_at, input int rst_at);
    int pulses;
    bit exp_busy;
    pulses = 0;
    @(posedge clk); #1;
    IR_vld = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      IR_vld = (c == vld2_at);
      rst    = (c == rst_at);
      exp_busy = (c >= 1) && (c <= 5) && ((rst_at == 0) || (c <= rst_at));
      if (err_vld) pulses++;
      if (c <= 7 || busy) check_val({tag, "/busy"}, busy, exp_busy);
      if (c == 6 && rst_at == 0) begin
        check_val({tag, "/err_vld"}, err_vld, 1'b1);
        check_val({tag, "/error"}, error, exp_err);
        check_val({tag, "/lost_line"}, lost_line, exp_lost);
        if (chk3) check_val({tag, "/error_sh3"}, error3, exp_err3);
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check_val({tag, "/rst_error"}, error, 12'h000);
        check_val({tag, "/rst_err_vld"}, err_vld, 1'b0);
        check_val({tag, "/rst_busy"}, busy, 1'b0);
        check_val({tag, "/rst_lost"}, lost_line, 1'b0);
      end
    end
    IR_vld = 1'b0;
    rst    = 1'b0;
    check_val({tag, "/pulses"}, pulses, (rst_at == 0) ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("reset/error", error, 12'h000);
    check_val("reset/err_vld", err_vld, 1'b0);
    check_val("reset/busy", busy, 1'b0);
    check_val("reset/lost_line", lost_line, 1'b0);

    // Balanced readings: zero error.
    set_in(12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 1'b1);
    do_round("balanced", 12'h000, 1'b0, 1'b1, 12'h000, 0, 0);

    // acc = 4095*8 = 32760; >>>5 = 1023; >>>3 = 4095 (wraps to 0xFFF, clamps to 0x7FF)
    set_in(12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1);
`ifdef IR_ERR_SAT_EN
    do_round("r3_max", 12'h3FF, 1'b0, 1'b1, 12'h7FF, 0, 0);
`else
    do_round("r3_max", 12'h3FF, 1'b0, 1'b1, 12'hFFF, 0, 0);
`endif

    // acc = -61425; >>>5 = -1920 (0x880); >>>3 = -7679 (wraps to 0x201, clamps to 0x800)
    set_in(12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
`ifdef IR_ERR_SAT_EN
    do_round("left_max", 12'h880, 1'b0, 1'b1, 12'h800, 0, 0);
`else
    do_round("left_max", 12'h880, 1'b0, 1'b1, 12'h201, 0, 0);
`endif

    // Eight absent rounds: error holds, lost_line rises on the 8th.
    set_in(12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      do_round($sformatf("absent%0d", k), 12'h880, (k >= 8), 1'b0, 12'h000, 0, 0);
    end

    // Present again: acc = 0x100 = 256, >>>5 = 8; lost_line clears.
    set_in(12'h200, 12'h000, 12'h000, 12'h000, 12'h100, 12'h000, 12'h000, 12'h000, 1'b1);
    do_round("recover", 12'h008, 1'b0, 1'b0, 12'h000, 0, 0);

    // Mixed signs: (5-9)<<0 + (0-0x40)<<2 = -4 - 256 = -260; >>>5 = floor(-8.125) = -9
    set_in(12'h005, 12'h000, 12'h000, 12'h000, 12'h009, 12'h000, 12'h040, 12'h000, 1'b1);
    do_round("floor_neg", 12'hFF7, 1'b0, 1'b0, 12'h000, 0, 0);

    // Second IR_vld at N+2 while busy is dropped.
    set_in(12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 1'b1);
    do_round("busy_vld", 12'h000, 1'b0, 1'b0, 12'h000, 2, 0);

    // Put a nonzero error in place, then abort a round with reset at N+3.
    set_in(12'h200, 12'h000, 12'h000, 12'h000, 12'h100, 12'h000, 12'h000, 12'h000, 1'b1);
    do_round("pre_rst", 12'h008, 1'b0, 1'b0, 12'h000, 0, 0);
    set_in(12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1);
    do_round("mid_rst", 12'h000, 1'b0, 1'b0, 12'h000, 0, 3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
